// File: rtl/md5_pkg.sv
// Shared MD5 constants, round helpers and the engine state type.
package md5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2
    } md5_state_t;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

    // Byte-serial form of the IV, i.e. what the digest shows before any block.
    localparam logic [127:0] MD5_DIGEST_IV = 128'h0123456789abcdeffedcba9876543210;

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] MD5_S [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Message word used by step i; every round formula is mod 16, so only i[3:0] matters.
    function automatic logic [3:0] md5_msg_idx(input logic [5:0] i);
        logic [3:0] j;
        j = i[3:0];
        case (i[5:4])
            2'd0:    return j;
            2'd1:    return j * 4'd5 + 4'd1;
            2'd2:    return j * 4'd3 + 4'd5;
            default: return j * 4'd7;
        endcase
    endfunction

    function automatic logic [31:0] md5_f(input logic [1:0] round,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] z);
        case (round)
            2'd0:    return (x & y) | (~x & z);
            2'd1:    return (x & z) | (y & ~z);
            2'd2:    return x ^ y ^ z;
            default: return y ^ (x | ~z);
        endcase
    endfunction

endpackage

// File: rtl/md5_core_if.sv
// Start/done block handshake between the padder side and the MD5 engine.
interface md5_core_if #(
    parameter int COUNT_W = 32
);
    logic               start;
    logic               init;
    logic [511:0]       block;
    logic               busy;
    logic               done;
    logic [127:0]       digest;
    logic [COUNT_W-1:0] block_count;

    modport master (
        output start, init, block,
        input  busy, done, digest, block_count
    );

    modport slave (
        input  start, init, block,
        output busy, done, digest, block_count
    );
endinterface

// File: rtl/md5_step.sv
// One combinational MD5 step; the step index selects K, the shift and the round function.
module md5_step
    import md5_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] m,
    input  logic [5:0]  idx,
    output logic [31:0] a_n,
    output logic [31:0] b_n,
    output logic [31:0] c_n,
    output logic [31:0] d_n
);
    logic [31:0] t;
    logic [31:0] rot;
    logic [4:0]  sh;

    assign sh  = MD5_S[idx];
    assign t   = a + md5_f(idx[5:4], b, c, d) + MD5_K[idx] + m;
    // Shift amounts are never zero, so the right shift by 32-sh stays in range.
    assign rot = (t << sh) | (t >> (6'd32 - {1'b0, sh}));

    assign a_n = d;
    assign b_n = b + rot;
    assign c_n = b;
    assign d_n = c;
endmodule

// File: rtl/md5_core.sv
// Iterative MD5 compression engine with chaining across blocks.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; digest/block_count hold last result
//   ST_RUN   | retiring STEPS_PER_CYCLE steps per clock, step 0..63
//   ST_FINAL | fold working regs into the chain, publish digest, pulse done
module md5_core
    import md5_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1,
    parameter int COUNT_W         = 32
) (
    input  logic      clk,
    input  logic      rst,
    md5_core_if.slave bus
);
    localparam int SPC = STEPS_PER_CYCLE;

    if (!(SPC == 1 || SPC == 2 || SPC == 4 || SPC == 8 || SPC == 16)) begin : g_bad_steps
        $error("md5_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    md5_state_t         state_q, state_d;
    logic [5:0]         step_q;
    logic [31:0]        a_q, b_q, c_q, d_q;
    logic [31:0]        h_q [4];
    logic [COUNT_W-1:0] count_q;
    logic [127:0]       digest_q;
    logic               done_q;
    logic               step_last;

    logic [31:0] ca [SPC+1];
    logic [31:0] cb [SPC+1];
    logic [31:0] cc [SPC+1];
    logic [31:0] cd [SPC+1];
    logic [31:0] sum [4];

    assign ca[0] = a_q;
    assign cb[0] = b_q;
    assign cc[0] = c_q;
    assign cd[0] = d_q;

    for (genvar k = 0; k < SPC; k++) begin : g_step
        logic [5:0] idx;
        logic [3:0] g;
        assign idx = step_q + 6'(k);
        assign g   = md5_msg_idx(idx);
        md5_step u_step (
            .a   (ca[k]),
            .b   (cb[k]),
            .c   (cc[k]),
            .d   (cd[k]),
            .m   (bus.block[{g, 5'b0} +: 32]),
            .idx (idx),
            .a_n (ca[k+1]),
            .b_n (cb[k+1]),
            .c_n (cc[k+1]),
            .d_n (cd[k+1])
        );
    end

    assign step_last = (step_q == 6'(64 - SPC));

    assign sum[0] = h_q[0] + a_q;
    assign sum[1] = h_q[1] + b_q;
    assign sum[2] = h_q[2] + c_q;
    assign sum[3] = h_q[3] + d_q;

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.digest      = digest_q;
    assign bus.block_count = count_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept in IDLE, leave RUN once step 63 has been applied.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (step_last) state_d = ST_FINAL;
            ST_FINAL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, fold and publish in FINAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            h_q[0]   <= MD5_IV_A;
            h_q[1]   <= MD5_IV_B;
            h_q[2]   <= MD5_IV_C;
            h_q[3]   <= MD5_IV_D;
            count_q  <= '0;
            digest_q <= MD5_DIGEST_IV;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        step_q <= '0;
                        if (bus.init) begin
                            a_q     <= MD5_IV_A;
                            b_q     <= MD5_IV_B;
                            c_q     <= MD5_IV_C;
                            d_q     <= MD5_IV_D;
                            h_q[0]  <= MD5_IV_A;
                            h_q[1]  <= MD5_IV_B;
                            h_q[2]  <= MD5_IV_C;
                            h_q[3]  <= MD5_IV_D;
                            count_q <= '0;
                        end else begin
                            a_q <= h_q[0];
                            b_q <= h_q[1];
                            c_q <= h_q[2];
                            d_q <= h_q[3];
                        end
                    end
                end
                ST_RUN: begin
                    a_q    <= ca[SPC];
                    b_q    <= cb[SPC];
                    c_q    <= cc[SPC];
                    d_q    <= cd[SPC];
                    step_q <= step_q + 6'(SPC);
                end
                ST_FINAL: begin
                    h_q[0]   <= sum[0];
                    h_q[1]   <= sum[1];
                    h_q[2]   <= sum[2];
                    h_q[3]   <= sum[3];
                    // The digest has its own register so a new init accept does not disturb it.
                    digest_q <= {bswap32(sum[0]), bswap32(sum[1]), bswap32(sum[2]), bswap32(sum[3])};
                    count_q  <= count_q + 1'b1;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_md5_core.sv
// Directed-vector bench for md5_core: known digests, latency, handshake and reset abort.
module tb_md5_core;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    localparam logic [127:0] DIG_IV    = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] DIG_A56   = 128'h3b0c8ac703f828b04c6c197006d17218;

    md5_core_if #(.COUNT_W(32)) bus1 ();
    md5_core_if #(.COUNT_W(32)) bus4 ();

    md5_core #(.STEPS_PER_CYCLE(1), .COUNT_W(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    md5_core #(.STEPS_PER_CYCLE(4), .COUNT_W(32)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run one block on the S=1 instance; optionally pulse start/init mid-run at cycle pulse_at.
    task automatic run1(input logic [511:0] blk, input logic ini, input int pulse_at, output int lat);
        bus1.block = blk;
        bus1.init  = ini;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        bus1.init  = 1'b0;
        check_val("busy_after_accept", 128'(bus1.busy), 128'd1);
        lat = 0;
        while (bus1.done !== 1'b1 && lat < 200) begin
            bus1.start = (lat == pulse_at);
            bus1.init  = (lat == pulse_at);
            @(posedge clk); #1;
            lat++;
        end
        bus1.start = 1'b0;
        bus1.init  = 1'b0;
        check_val("done_seen", 128'(bus1.done), 128'd1);
        check_val("busy_low_in_done", 128'(bus1.busy), 128'd0);
        @(posedge clk); #1;
        check_val("done_one_cycle", 128'(bus1.done), 128'd0);
    endtask

    logic [511:0] blk_empty, blk_abc, blk_a1, blk_a2;

    initial begin
        int lat, n, c1, c2, dn;

        blk_empty = '0;
        blk_empty[31:0] = 32'h00000080;
        blk_abc = '0;
        blk_abc[31:0] = 32'h80636261;
        blk_abc[14*32 +: 32] = 32'h00000018;
        blk_a1 = '0;
        for (int i = 0; i < 14; i++) blk_a1[i*32 +: 32] = 32'h61616161;
        blk_a1[14*32 +: 32] = 32'h00000080;
        blk_a2 = '0;
        blk_a2[14*32 +: 32] = 32'h000001c0;

        bus1.start = 1'b0; bus1.init = 1'b0; bus1.block = '0;
        bus4.start = 1'b0; bus4.init = 1'b0; bus4.block = '0;
        rst = 1'b1;

        repeat (2) @(negedge clk);
        check_val("reset_digest", bus1.digest, DIG_IV);
        check_val("reset_count", 128'(bus1.block_count), 128'd0);
        check_val("reset_busy", 128'(bus1.busy), 128'd0);
        check_val("reset_done", 128'(bus1.done), 128'd0);
        check_val("reset_digest_s4", bus4.digest, DIG_IV);
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty message.
        run1(blk_empty, 1'b1, -1, lat);
        check_val("empty_latency", 128'(lat), 128'd65);
        check_val("empty_digest", bus1.digest, DIG_EMPTY);
        check_val("empty_count", 128'(bus1.block_count), 128'd1);

        // "abc" as a fresh message: count restarts.
        run1(blk_abc, 1'b1, -1, lat);
        check_val("abc_digest", bus1.digest, DIG_ABC);
        check_val("abc_count", 128'(bus1.block_count), 128'd1);

        // Two-block chaining, 56 x "a".
        run1(blk_a1, 1'b1, -1, lat);
        run1(blk_a2, 1'b0, -1, lat);
        check_val("a56_digest", bus1.digest, DIG_A56);
        check_val("a56_count", 128'(bus1.block_count), 128'd2);

        // start/init pulsed while busy must be ignored.
        run1(blk_abc, 1'b1, 20, lat);
        check_val("busy_pulse_latency", 128'(lat), 128'd65);
        check_val("busy_pulse_digest", bus1.digest, DIG_ABC);
        check_val("busy_pulse_count", 128'(bus1.block_count), 128'd1);

        // start held high: one block per 66 cycles.
        bus1.block = blk_abc;
        bus1.init  = 1'b1;
        bus1.start = 1'b1;
        n = 0;
        while (bus1.done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        check_val("held_done1", 128'(bus1.done), 128'd1);
        c1 = cyc;
        @(posedge clk); #1;
        check_val("held_reaccept_busy", 128'(bus1.busy), 128'd1);
        n = 0;
        while (bus1.done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        check_val("held_done2", 128'(bus1.done), 128'd1);
        c2 = cyc;
        bus1.start = 1'b0;
        bus1.init  = 1'b0;
        check_val("held_gap", 128'(c2 - c1), 128'd66);
        check_val("held_digest", bus1.digest, DIG_ABC);
        @(posedge clk); #1;
        check_val("held_released_busy", 128'(bus1.busy), 128'd0);

        // Reset at step 30 aborts the block with no done.
        bus1.block = blk_abc;
        bus1.init  = 1'b1;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        bus1.init  = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check_val("abort_busy", 128'(bus1.busy), 128'd0);
        check_val("abort_done", 128'(bus1.done), 128'd0);
        check_val("abort_digest", bus1.digest, DIG_IV);
        check_val("abort_count", 128'(bus1.block_count), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus1.done === 1'b1) dn++;
        end
        check_val("abort_no_done", 128'(dn), 128'd0);
        run1(blk_abc, 1'b0, -1, lat);
        check_val("abort_then_abc_digest", bus1.digest, DIG_ABC);
        check_val("abort_then_abc_count", 128'(bus1.block_count), 128'd1);

        // Four steps per cycle: 17-cycle latency.
        bus4.block = blk_abc;
        bus4.init  = 1'b1;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        bus4.init  = 1'b0;
        lat = 0;
        while (bus4.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        check_val("s4_latency", 128'(lat), 128'd17);
        check_val("s4_digest", bus4.digest, DIG_ABC);
        check_val("s4_count", 128'(bus4.block_count), 128'd1);
        @(posedge clk); #1;
        check_val("s4_done_one_cycle", 128'(bus4.done), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md5_core.md
# md5_core

Parametrised iterative MD5 compression engine with multi-block chaining and a start/done handshake. It processes one padded 512-bit block per transaction. Each clock cycle it retires `STEPS_PER_CYCLE` of the 64 MD5 steps and accumulates the chaining value across blocks. It sits between the message padder/block buffer and the digest output register. It replaces the single-shot, combinational, enable-edge-triggered updater.

## Interface
- `STEPS_PER_CYCLE`, default 1: MD5 steps retired per clock. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- `COUNT_W`, default 32: width of the processed-block counter.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: request to process `block`. Sampled only in IDLE.
- `init`, in, 1: sampled together with `start`.
  - 1: load the chain from the standard IV (new message).
  - 0: continue from the current chain value.
- `block`, in, 512: padded message block. Word i is `block[32i+31:32i]`, little-endian bytes as in RFC 1321. Must be held stable while `busy`.
- `busy`, out, 1: high from the accepting edge until `done`.
- `done`, out, 1: one-cycle pulse; `digest` is valid from this cycle onward.
- `digest`, out, 128: byte-serial MD5 output, `{bswap(A),bswap(B),bswap(C),bswap(D)}` of the chain. Held until the next `done`.
- `block_count`, out, `COUNT_W`: blocks completed since the last `init` or reset.

## Operation
- **State registers:** chain `H[0..3]`, working `a,b,c,d`, step counter `step[5:0]`, FSM {IDLE, RUN, FINAL}.
- **IDLE, `start`=1:**
  - Working regs load from the IV if `init`=1; otherwise they load from `H`.
  - If `init`=1, `H` is also set to the IV and `block_count` is cleared.
  - `step` is set to 0; go to RUN.
  - `start`=0 in IDLE: hold.
- **RUN:** each edge applies steps `step` .. `step+S-1` in sequence, combinationally chained. Then `step += S`. When the edge completes step 63, go to FINAL.
- **Step i:**
  - `f` = F/G/H/I for round `i/16`.
  - `g` = i, (5i+1) mod 16, (3i+5) mod 16 or 7i mod 16, by round.
  - `t = a + f(b,c,d) + K[i] + M[g]`, modulo 2^32.
  - New `(a,b,c,d) = (d, b + rotl(t, s[i]), b, c)`.
- **FINAL:**
  - `H[j] += working[j]`, modulo 2^32.
  - `block_count += 1`, wrapping at 2^COUNT_W.
  - Pulse `done`; go to IDLE.
- **`start` while busy:** ignored, with no queuing. `init` is ignored outside the accepting edge.
- **Reset, including mid-operation:**
  - FSM goes to IDLE, `step`=0, `H`=IV, working regs = 0, `block_count`=0.
  - `busy`=0, `done`=0, and `digest` reflects the IV (`0123456789abcdeffedcba9876543210`).
  - No `done` is generated for the aborted block.
- **Arithmetic:** all additions are 32-bit unsigned with carries discarded. Rotations are left rotations by the constant `s[i]`.

## Timing
- Let N = 64/S.
- Accepting edge E0. RUN covers edges E1..EN. FINAL is edge EN+1.
- `done`=1 for exactly the one cycle following EN+1. Latency from the accepting edge to `done` is N+1 cycles: 65 for S=1, 17 for S=4.
- `busy` rises after E0 and falls with the `done` pulse, i.e. it is low in the cycle `done` is high.
- The earliest next accept is the edge ending the `done` cycle. Throughput is one block per N+2 cycles.
- `digest` and `block_count` update on EN+1. Both are registered outputs with no combinational path from inputs.

## Structure
- **Package `md5_pkg`:**
  - IV constants.
  - `K[0:63]` table and `S[0:63]` shift table.
  - Functions: `md5_msg_idx(i)`, `md5_f(round,x,y,z)` and `bswap32`.
  - FSM state enum.
- **Sub-module `md5_step`:** purely combinational single step.
  - Inputs: a, b, c, d, the selected message word, and a step index used to select K, s and f.
  - `md5_core` instantiates it `STEPS_PER_CYCLE` times in a generate chain.

## Test plan
- **Empty string.** `init`=1, block word0=`32'h00000080`, all other words 0 → after 65 cycles (S=1) `digest`=`d41d8cd98f00b204e9800998ecf8427e`, `block_count`=1, `done` high one cycle.
- **"abc".** word0=`32'h80636261`, word14=`32'h18` → `digest`=`900150983cd24fb0d6963f7d28e17f72`. Repeat with S=4; latency is 17 cycles.
- **Two-block chaining.** The 56 × "a" message: block 1 with `init`=1, block 2 (length word 448) with `init`=0 → `digest`=`3b0c8ac703f828b04c6c197006d17218`, `block_count`=2.
- **Busy and back-to-back behaviour.**
  - `start` pulsed while `busy` mid-run: ignored; the digest still matches "abc".
  - `start` held high continuously: a new block is accepted every N+2 cycles.
- **Reset mid-run.** `rst` at step 30 → `busy`=0 immediately and no `done`. `digest`=`0123456789abcdeffedcba9876543210`, `block_count`=0. A subsequent "abc" with `init`=0 still yields `900150983cd24fb0d6963f7d28e17f72`.
